// File: rtl/fib_wb_capture_pkg.sv
// Shared constants and register decode for the Fibonacci value capture block.
package fib_pkg;

    localparam logic [7:0] FIB_CTRL   = 8'h00;
    localparam logic [7:0] FIB_STATUS = 8'h04;
    localparam logic [7:0] FIB_DATA   = 8'h08;
    localparam logic [7:0] FIB_COUNT  = 8'h0C;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_CLR_BIT     = 2;
    localparam int CTRL_DIV_LSB     = 8;
    localparam int FIB_DIV_W        = 8;

    localparam int STAT_LEVEL_W     = 8;
    localparam int STAT_EMPTY_BIT   = 16;
    localparam int STAT_FULL_BIT    = 17;
    localparam int STAT_OVF_BIT     = 18;
    localparam int STAT_WRAP_BIT    = 19;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STATUS,
        REG_DATA,
        REG_COUNT,
        REG_RSVD
    } fib_reg_e;

    // Maps a word index inside the claimed page onto a register selector.
    function automatic fib_reg_e fib_decode(input logic [5:0] word);
        fib_reg_e sel;
        case (word)
            FIB_CTRL[7:2]:   sel = REG_CTRL;
            FIB_STATUS[7:2]: sel = REG_STATUS;
            FIB_DATA[7:2]:   sel = REG_DATA;
            FIB_COUNT[7:2]:  sel = REG_COUNT;
            default:         sel = REG_RSVD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/fib_wb_capture_if.sv
// Wishbone classic slave bus bundle for the capture block.
interface fib_wb_capture_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/fib_wb_capture_fifo.sv
// Small synchronous FIFO holding captured samples; pointers carry an extra wrap bit.
module fib_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer update; clear dominates any concurrent push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are only ever observed through a valid head.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/fib_wb_capture.sv
// Samples the generator value at a programmable rate into a FIFO and exposes
// the samples, level, overflow and wrap flags over a Wishbone slave port.
module fib_wb_capture
    import fib_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_i,
    fib_wb_capture_if.slave  wb
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                 w_claimed;
    logic                 w_req;
    logic                 w_ctrl_wr;
    logic                 w_clr;
    logic                 w_data_rd;
    logic                 w_pop;
    logic                 w_sample;
    logic                 w_full_eff;
    logic                 w_push;
    logic                 w_drop;
    fib_reg_e             w_reg;
    logic [31:0]          w_rd_data;
    logic [WIDTH-1:0]     w_head;
    logic [LW-1:0]        w_level;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_unused;

    logic                 r_en;
    logic                 r_oneshot;
    logic [FIB_DIV_W-1:0] r_div;
    logic [FIB_DIV_W-1:0] r_div_cnt;
    logic [31:0]          r_count;
    logic                 r_ovf;
    logic                 r_wrap;
    logic                 r_have_last;
    logic [WIDTH-1:0]     r_last;
    logic                 r_ack;
    logic [31:0]          r_dat;

    assign w_claimed  = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_req      = wb.wbs_stb_i && wb.wbs_cyc_i && w_claimed && !r_ack;
    assign w_reg      = fib_decode(wb.wbs_adr_i[7:2]);
    assign w_ctrl_wr  = w_req && wb.wbs_we_i && (w_reg == REG_CTRL);
    assign w_clr      = w_ctrl_wr && wb.wbs_sel_i[0] && wb.wbs_dat_i[CTRL_CLR_BIT];
    assign w_data_rd  = w_req && !wb.wbs_we_i && (w_reg == REG_DATA);
    assign w_pop      = w_data_rd && !w_empty;
    assign w_sample   = r_en && (r_div_cnt == r_div);
    assign w_full_eff = w_full && !w_pop;
    assign w_push     = w_sample && !w_full_eff && !w_clr;
    assign w_drop     = w_sample && w_full_eff && !w_clr;

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;

    assign w_unused = ^{wb.wbs_sel_i[3:2], wb.wbs_adr_i[1:0],
                        wb.wbs_dat_i[31:16], wb.wbs_dat_i[7:3]};

    fib_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clr),
        .i_data  (value_i),
        .o_head  (w_head),
        .o_level (w_level),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Read-data mux for the addressed register; DATA reads 0 when nothing is queued.
    always_comb begin
        w_rd_data = '0;
        case (w_reg)
            REG_CTRL: begin
                w_rd_data[CTRL_EN_BIT]                  = r_en;
                w_rd_data[CTRL_ONESHOT_BIT]             = r_oneshot;
                w_rd_data[CTRL_DIV_LSB +: FIB_DIV_W]    = r_div;
            end
            REG_STATUS: begin
                w_rd_data[LW-1:0]                       = w_level;
                w_rd_data[STAT_EMPTY_BIT]               = w_empty;
                w_rd_data[STAT_FULL_BIT]                = w_full;
                w_rd_data[STAT_OVF_BIT]                 = r_ovf;
                w_rd_data[STAT_WRAP_BIT]                = r_wrap;
            end
            REG_DATA: begin
                if (!w_empty) w_rd_data[WIDTH-1:0] = w_head;
            end
            REG_COUNT: begin
                w_rd_data = r_count;
            end
            default: begin
                w_rd_data = '0;
            end
        endcase
    end

    // Control register; a oneshot overflow disables capture unless firmware writes EN now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en      <= 1'b0;
            r_oneshot <= 1'b0;
            r_div     <= '0;
        end else begin
            if (w_ctrl_wr && wb.wbs_sel_i[0]) begin
                r_en      <= wb.wbs_dat_i[CTRL_EN_BIT];
                r_oneshot <= wb.wbs_dat_i[CTRL_ONESHOT_BIT];
            end else if (w_drop && r_oneshot) begin
                r_en <= 1'b0;
            end
            if (w_ctrl_wr && wb.wbs_sel_i[1]) begin
                r_div <= wb.wbs_dat_i[CTRL_DIV_LSB +: FIB_DIV_W];
            end
        end
    end

    // Rate divider; any CTRL write restarts the sampling phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_ctrl_wr || !r_en) begin
            r_div_cnt <= '0;
        end else if (w_sample) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + FIB_DIV_W'(1);
        end
    end

    // Sample count, sticky flags and last-pushed value for the wrap comparison.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_wrap      <= 1'b0;
            r_have_last <= 1'b0;
            r_last      <= '0;
        end else if (w_clr) begin
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_wrap      <= 1'b0;
            r_have_last <= 1'b0;
            r_last      <= '0;
        end else begin
            if (w_push) begin
                r_count     <= r_count + 32'd1;
                r_last      <= value_i;
                r_have_last <= 1'b1;
                if (r_have_last && (value_i < r_last)) r_wrap <= 1'b1;
            end
            if (w_drop && !r_oneshot) r_ovf <= 1'b1;
        end
    end

    // Registered single-cycle acknowledge with data valid only in the ack cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else if (w_req) begin
            r_ack <= 1'b1;
            r_dat <= wb.wbs_we_i ? 32'd0 : w_rd_data;
        end else begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end
    end
endmodule

// File: tb/tb_fib_wb_capture.sv
// Directed bench for fib_wb_capture: oneshot fill, divider spacing, overflow,
// clear, wrap detection, asynchronous reset and reserved/unclaimed addresses.
module tb_fib_wb_capture;

    localparam logic [31:0] CTRL_ADR   = 32'h3000_0000;
    localparam logic [31:0] STATUS_ADR = 32'h3000_0004;
    localparam logic [31:0] DATA_ADR   = 32'h3000_0008;
    localparam logic [31:0] COUNT_ADR  = 32'h3000_000C;
    localparam logic [31:0] RSVD_ADR   = 32'h3000_0010;
    localparam logic [31:0] FAR_ADR    = 32'h3000_0100;

    logic        clk;
    logic        reset;
    logic [31:0] valueIn;
    logic        autoValue;
    int          totalChecks;
    int          badChecks;

    fib_wb_capture_if wbBus();

    fib_wb_capture #(
        .WIDTH     (32),
        .DEPTH     (8),
        .BASE_ADDR (32'h3000_0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .value_i (valueIn),
        .wb      (wbBus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Generator model: a new value shortly after every rising edge.
    initial begin
        valueIn   = 32'd100;
        autoValue = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (autoValue) valueIn = valueIn + 32'd1;
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One Wishbone classic access, bounded to 10 cycles of waiting for ack.
    task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                 input logic [31:0] wdata, input logic [3:0] sel,
                                 output logic [31:0] rdata, output logic acked);
        @(negedge clk);
        wbBus.wbs_cyc_i = 1'b1;
        wbBus.wbs_stb_i = 1'b1;
        wbBus.wbs_we_i  = we;
        wbBus.wbs_adr_i = adr;
        wbBus.wbs_dat_i = wdata;
        wbBus.wbs_sel_i = sel;
        acked = 1'b0;
        rdata = '0;
        for (int i = 0; i < 10 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (wbBus.wbs_ack_o) begin
                acked = 1'b1;
                rdata = wbBus.wbs_dat_o;
            end
        end
        wbBus.wbs_cyc_i = 1'b0;
        wbBus.wbs_stb_i = 1'b0;
        wbBus.wbs_we_i  = 1'b0;
        wbBus.wbs_dat_i = '0;
    endtask

    task automatic wbWrite(input string tag, input logic [31:0] adr,
                           input logic [31:0] wdata, input logic [3:0] sel);
        logic [31:0] unusedData;
        logic        acked;
        applyStimulus(1'b1, adr, wdata, sel, unusedData, acked);
        checkOutput({tag, " ack"}, 32'(acked), 32'd1);
    endtask

    task automatic wbReadCheck(input string tag, input logic [31:0] adr,
                               input logic [31:0] expected);
        logic [31:0] rdata;
        logic        acked;
        applyStimulus(1'b0, adr, 32'd0, 4'hF, rdata, acked);
        checkOutput({tag, " ack"}, 32'(acked), 32'd1);
        checkOutput(tag, rdata, expected);
    endtask

    task automatic wbRead(input string tag, input logic [31:0] adr,
                          output logic [31:0] rdata);
        logic acked;
        applyStimulus(1'b0, adr, 32'd0, 4'hF, rdata, acked);
        checkOutput({tag, " ack"}, 32'(acked), 32'd1);
    endtask

    initial begin
        logic [31:0] firstVal;
        logic [31:0] d0, d1, d2;
        logic [31:0] rdata;
        logic        acked;

        totalChecks     = 0;
        badChecks       = 0;
        reset           = 1'b1;
        wbBus.wbs_cyc_i = 1'b0;
        wbBus.wbs_stb_i = 1'b0;
        wbBus.wbs_we_i  = 1'b0;
        wbBus.wbs_sel_i = 4'h0;
        wbBus.wbs_adr_i = '0;
        wbBus.wbs_dat_i = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ack", 32'(wbBus.wbs_ack_o), 32'd0);
        checkOutput("reset dat", wbBus.wbs_dat_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        wbReadCheck("status after reset", STATUS_ADR, 32'h0001_0000);
        wbReadCheck("count after reset", COUNT_ADR, 32'd0);

        // Oneshot fill: first sample is taken on the edge after the write ack,
        // which sees the value the generator presents one step later.
        wbWrite("ctrl oneshot", CTRL_ADR, 32'h0000_0003, 4'hF);
        firstVal = valueIn + 32'd1;
        repeat (12) @(posedge clk);
        wbReadCheck("oneshot status", STATUS_ADR, 32'h0002_0008);
        wbReadCheck("oneshot ctrl", CTRL_ADR, 32'h0000_0002);
        wbReadCheck("oneshot count", COUNT_ADR, 32'd8);
        for (int i = 0; i < 8; i++) begin
            wbReadCheck($sformatf("oneshot data[%0d]", i), DATA_ADR, firstVal + 32'(i));
        end
        wbReadCheck("empty data", DATA_ADR, 32'd0);
        wbReadCheck("empty status", STATUS_ADR, 32'h0001_0000);

        // Divider of 2: consecutive samples three generator steps apart.
        wbWrite("ctrl div2", CTRL_ADR, 32'h0000_0201, 4'hF);
        repeat (15) @(posedge clk);
        wbRead("div data0", DATA_ADR, d0);
        wbRead("div data1", DATA_ADR, d1);
        wbRead("div data2", DATA_ADR, d2);
        checkOutput("div step 0-1", d1 - d0, 32'd3);
        checkOutput("div step 1-2", d2 - d1, 32'd3);
        wbWrite("ctrl clr1", CTRL_ADR, 32'h0000_0004, 4'hF);
        wbReadCheck("clr1 status", STATUS_ADR, 32'h0001_0000);
        wbReadCheck("clr1 count", COUNT_ADR, 32'd0);

        // Continuous capture without reads overflows the FIFO.
        wbWrite("ctrl run", CTRL_ADR, 32'h0000_0001, 4'hF);
        repeat (20) @(posedge clk);
        wbReadCheck("ovf status", STATUS_ADR, 32'h0006_0008);
        wbReadCheck("ovf count", COUNT_ADR, 32'd8);
        wbWrite("ctrl clr2", CTRL_ADR, 32'h0000_0004, 4'hF);
        wbReadCheck("clr2 status", STATUS_ADR, 32'h0001_0000);
        wbReadCheck("clr2 count", COUNT_ADR, 32'd0);
        wbReadCheck("clr2 ctrl", CTRL_ADR, 32'd0);

        // Wrap: exactly three samples, the last smaller than its predecessor.
        autoValue = 1'b0;
        valueIn   = 32'hFFFF_FFFE;
        wbWrite("ctrl wrap run", CTRL_ADR, 32'h0000_0001, 4'hF);
        @(posedge clk);
        #1;
        valueIn = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        valueIn = 32'h0000_0001;
        wbWrite("ctrl wrap stop", CTRL_ADR, 32'h0000_0000, 4'hF);
        wbReadCheck("wrap status", STATUS_ADR, 32'h0008_0003);
        wbReadCheck("wrap data0", DATA_ADR, 32'hFFFF_FFFE);
        wbReadCheck("wrap data1", DATA_ADR, 32'hFFFF_FFFF);
        wbReadCheck("wrap data2", DATA_ADR, 32'h0000_0001);
        wbReadCheck("wrap drained", STATUS_ADR, 32'h0009_0000);

        // Asynchronous reset while a STATUS read is being acknowledged.
        autoValue = 1'b1;
        wbWrite("ctrl pre reset", CTRL_ADR, 32'h0000_0001, 4'hF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        wbBus.wbs_cyc_i = 1'b1;
        wbBus.wbs_stb_i = 1'b1;
        wbBus.wbs_we_i  = 1'b0;
        wbBus.wbs_sel_i = 4'hF;
        wbBus.wbs_adr_i = STATUS_ADR;
        @(posedge clk);
        #1;
        checkOutput("ack before reset", 32'(wbBus.wbs_ack_o), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async reset ack", 32'(wbBus.wbs_ack_o), 32'd0);
        checkOutput("async reset dat", wbBus.wbs_dat_o, 32'd0);
        wbBus.wbs_cyc_i = 1'b0;
        wbBus.wbs_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wbReadCheck("post reset status", STATUS_ADR, 32'h0001_0000);
        wbReadCheck("post reset ctrl", CTRL_ADR, 32'd0);
        wbReadCheck("post reset count", COUNT_ADR, 32'd0);

        // Only lane 1 enabled: DIV updates, EN/CLR bits are ignored.
        wbWrite("ctrl lane1", CTRL_ADR, 32'h0000_0306, 4'b0010);
        wbReadCheck("lane1 ctrl", CTRL_ADR, 32'h0000_0300);
        wbReadCheck("lane1 status", STATUS_ADR, 32'h0001_0000);

        // Reserved offset acks with zero; an address outside the page never acks.
        wbReadCheck("reserved read", RSVD_ADR, 32'd0);
        applyStimulus(1'b0, FAR_ADR, 32'd0, 4'hF, rdata, acked);
        checkOutput("unclaimed no ack", 32'(acked), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
